// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (read only)
// and a data requester (read/write). Only one memory transaction is
// outstanding at a time. When both requesters want the port, arbitration is
// round-robin. Each busy period is bounded by a timeout. If the timeout
// expires, the transaction completes with an error.
//
// Ports
//   clk, rst              : single clock; synchronous active-high reset
//   i_req_i, i_addr_i     : fetch request (held until i_done_o) and address
//   i_done_o              : one-cycle pulse when the fetch completes
//   d_req_i, d_we_i,
//   d_be_i, d_addr_i,
//   d_wdata_i             : data request (held until d_done_o) and command
//   d_done_o              : one-cycle pulse when the data access completes
//   rdata_o, err_o        : read data and timeout flag, valid with a done pulse
//   mem_req_o, mem_we_o,
//   mem_be_o, mem_addr_o,
//   mem_wdata_o           : registered memory command, stable while mem_req_o
//   mem_rdata_i, mem_ack_i: memory response (ack ignored unless mem_req_o)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [AW-1:0]     i_addr_i,
    output logic              i_done_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [DW/8-1:0]   d_be_i,
    input  logic [AW-1:0]     d_addr_i,
    input  logic [DW-1:0]     d_wdata_i,
    output logic              d_done_o,
    output logic [DW-1:0]     rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_be_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;      // busy cycle number, 1 in the first busy cycle
    logic            last_d_r;   // 1 when data was the most recent grant

    logic            i_elig_s;
    logic            d_elig_s;
    logic            grant_i_s;
    logic            grant_d_s;
    logic            busy_s;
    logic            finish_s;
    logic            timeout_s;

    // Arbitration and completion decode.
    always_comb begin
        i_elig_s  = 1'b0;
        d_elig_s  = 1'b0;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        busy_s    = 1'b0;
        finish_s  = 1'b0;
        timeout_s = 1'b0;

        // A requester whose done pulse is showing still holds req this
        // cycle. Masking it here keeps that request from being granted again.
        i_elig_s = i_req_i & ~i_done_o;
        d_elig_s = d_req_i & ~d_done_o;

        if (i_elig_s && d_elig_s) begin
            grant_i_s = last_d_r;
            grant_d_s = ~last_d_r;
        end else begin
            grant_i_s = i_elig_s;
            grant_d_s = d_elig_s;
        end

        busy_s = (state_r == BUSY_I) || (state_r == BUSY_D);

        if (busy_s) begin
            timeout_s = ~mem_ack_i && (cnt_r == TIMEOUT_C);
            finish_s  = mem_ack_i || timeout_s;
        end else begin
            timeout_s = 1'b0;
            finish_s  = 1'b0;
        end
    end

    // FSM, busy counter, round-robin record and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            last_d_r    <= 1'b1;
            i_done_o    <= 1'b0;
            d_done_o    <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            // The done, error and read-data outputs are single-cycle
            // qualifiers, so they clear on every cycle unless set below.
            i_done_o <= 1'b0;
            d_done_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;

            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        state_r     <= BUSY_I;
                        cnt_r       <= ONE_C;
                        last_d_r    <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= '1;
                        mem_addr_o  <= i_addr_i;
                        mem_wdata_o <= '0;
                    end else if (grant_d_s) begin
                        state_r     <= BUSY_D;
                        cnt_r       <= ONE_C;
                        last_d_r    <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_be_o    <= d_be_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (finish_s) begin
                        state_r   <= IDLE;
                        cnt_r     <= '0;
                        mem_req_o <= 1'b0;
                        i_done_o  <= (state_r == BUSY_I);
                        d_done_o  <= (state_r == BUSY_D);
                        err_o     <= timeout_s;
                        // A timed-out transaction returns zero data.
                        rdata_o   <= timeout_s ? '0 : mem_rdata_i;
                    end else begin
                        cnt_r <= cnt_r + ONE_C;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
